// File: rtl/p_config_pkg.sv
// Shared types and derived sizes for the host-to-ASIC configuration engine.
package p_config_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONFIG = 2'd1,
      ST_SEND   = 2'd2,
      ST_LOCKED = 2'd3
   } state_e;

   localparam logic [1:0] MODE_IDLE   = 2'd0;
   localparam logic [1:0] MODE_CONFIG = 2'd1;
   localparam logic [1:0] MODE_LOCK   = 2'd2;

   localparam int FIELD_SCALAR_BASE = 1;

   function automatic int list_field_base(input int num_scalar);
      return num_scalar + FIELD_SCALAR_BASE;
   endfunction

   function automatic int total_words(input int num_scalar, input int num_list, input int list_depth);
      return num_scalar + num_list * list_depth;
   endfunction

   function automatic int beats_per_word(input int data_w, input int lane_w);
      return data_w / lane_w;
   endfunction

endpackage

// File: rtl/p_config_word_serializer.sv
// Splits one DATA_W word into LANE_W beats, most-significant lane first.
// A new word is accepted on the same edge the previous word's last beat leaves.
module p_config_word_serializer
   import p_config_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LANE_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              word_valid_i,
   input  logic [DATA_W-1:0] word_data_i,
   output logic              word_ready_o,
   output logic              beat_valid_o,
   output logic [LANE_W-1:0] beat_data_o,
   output logic              beat_last_o,
   input  logic              beat_ready_i
);

   localparam int BPW   = beats_per_word(DATA_W, LANE_W);
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              load_s, xfer_s;

   assign xfer_s       = valid_q && beat_ready_i;
   assign word_ready_o = !valid_q || (last_q && beat_ready_i);
   assign load_s       = word_valid_i && word_ready_o;

   assign beat_valid_o = valid_q;
   assign beat_data_o  = shift_q[DATA_W-1 -: LANE_W];
   assign beat_last_o  = last_q;

   // Next beat: load a fresh word, advance within the word, or drain to idle.
   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (load_s) begin
         valid_d = 1'b1;
         shift_d = word_data_i;
         cnt_d   = '0;
         last_d  = (BPW == 1);
      end else if (xfer_s) begin
         if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            shift_d = '0;
            cnt_d   = '0;
         end else begin
            shift_d = shift_q << LANE_W;
            cnt_d   = cnt_q + 1'b1;
            last_d  = (cnt_q == CNT_W'(BPW - 2));
         end
      end else begin
         valid_d = valid_q;
      end
   end

   // Beat register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/p_config_serializer.sv
// Host config register bank plus frame transmitter towards the ASIC link.
// Frame = every stored word in field order, each word split MSB lane first.
module p_config_serializer
   import p_config_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int LANE_W     = 8,
   parameter int NUM_SCALAR = 9,
   parameter int NUM_LIST   = 2,
   parameter int LIST_DEPTH = 15,
   parameter int FIELD_W    = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               mode_valid,
   input  logic [1:0]         mode,
   input  logic               wr_valid,
   input  logic [FIELD_W-1:0] wr_field,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic               send,
   output logic               tx_valid,
   output logic [LANE_W-1:0]  tx_data,
   output logic               tx_last,
   input  logic               tx_ready,
   output logic               done_pulse,
   output logic               busy,
   output logic               locked,
   output logic               err_overflow,
   output logic               err_field
);

   localparam int TOTAL     = total_words(NUM_SCALAR, NUM_LIST, LIST_DEPTH);
   localparam int ADDR_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int PTR_W     = $clog2(LIST_DEPTH + 1);
   localparam int LIST_BASE = list_field_base(NUM_SCALAR);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] words_q [TOTAL];
   logic [PTR_W-1:0]  ptr_q [NUM_LIST];
   logic [PTR_W-1:0]  ptr_d [NUM_LIST];
   logic              err_ovf_q, err_ovf_d;
   logic              err_fld_q, err_fld_d;
   logic [ADDR_W-1:0] widx_q, widx_d;
   logic              last_word_q, last_word_d;
   logic              done_q, boot_q, busy_q, locked_q;

   logic              wr_en_s, send_go_s, frame_end_s;
   logic [ADDR_W-1:0] wr_idx_s, load_idx_s;
   logic              word_valid_s, word_ready_s, word_load_s;
   logic [DATA_W-1:0] word_data_s;
   logic              beat_valid_s, beat_last_s;
   logic [LANE_W-1:0] beat_data_s;

   // Mode commands, field writes and send/complete transitions.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      err_ovf_d   = err_ovf_q;
      err_fld_d   = err_fld_q;
      wr_en_s     = 1'b0;
      wr_idx_s    = '0;
      send_go_s   = 1'b0;
      frame_end_s = 1'b0;
      if (mode_valid && (state_q != ST_SEND)) begin
         case (mode)
            MODE_CONFIG: begin
               state_d   = ST_CONFIG;
               err_ovf_d = 1'b0;
               err_fld_d = 1'b0;
               for (int l = 0; l < NUM_LIST; l++) begin
                  ptr_d[l] = '0;
               end
            end
            MODE_LOCK: begin
               if (state_q == ST_CONFIG) begin
                  state_d = ST_LOCKED;
               end else begin
                  state_d = state_q;
               end
            end
            MODE_IDLE: state_d = ST_IDLE;
            default:   state_d = state_q;
         endcase
      end else if (state_q == ST_CONFIG) begin
         if (wr_valid) begin
            if ((wr_field >= FIELD_W'(FIELD_SCALAR_BASE)) && (wr_field <= FIELD_W'(NUM_SCALAR))) begin
               wr_en_s  = 1'b1;
               wr_idx_s = ADDR_W'(wr_field - FIELD_W'(FIELD_SCALAR_BASE));
            end else begin
               // Flag as invalid unless a list field claims it below.
               err_fld_d = 1'b1;
               for (int l = 0; l < NUM_LIST; l++) begin
                  if (wr_field == FIELD_W'(LIST_BASE + l)) begin
                     err_fld_d = err_fld_q;
                     if (ptr_q[l] == PTR_W'(LIST_DEPTH)) begin
                        err_ovf_d = 1'b1;
                     end else begin
                        wr_en_s  = 1'b1;
                        wr_idx_s = ADDR_W'(NUM_SCALAR + l * LIST_DEPTH) + ADDR_W'(ptr_q[l]);
                        ptr_d[l] = ptr_q[l] + 1'b1;
                     end
                  end else begin
                     ptr_d[l] = ptr_d[l];
                  end
               end
            end
         end else begin
            wr_en_s = 1'b0;
         end
         if (send) begin
            send_go_s = 1'b1;
            state_d   = ST_SEND;
         end else begin
            send_go_s = 1'b0;
         end
      end else if (state_q == ST_SEND) begin
         if (beat_valid_s && tx_ready && beat_last_s && last_word_q) begin
            frame_end_s = 1'b1;
            state_d     = ST_CONFIG;
         end else begin
            frame_end_s = 1'b0;
         end
      end else begin
         state_d = state_q;
      end
   end

   // Word feed; a write committed alongside send is forwarded into word 0.
   always_comb begin
      load_idx_s   = (state_q == ST_SEND) ? widx_q : '0;
      word_valid_s = send_go_s || ((state_q == ST_SEND) && !last_word_q);
      if (wr_en_s && (wr_idx_s == load_idx_s)) begin
         word_data_s = wr_data;
      end else begin
         word_data_s = words_q[load_idx_s];
      end
      word_load_s = word_valid_s && word_ready_s;
      widx_d      = widx_q;
      last_word_d = last_word_q;
      if (word_load_s) begin
         widx_d      = load_idx_s + ADDR_W'(1);
         last_word_d = (load_idx_s == ADDR_W'(TOTAL - 1));
      end else begin
         widx_d = widx_q;
      end
   end

   // State, bank and status registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         for (int w = 0; w < TOTAL; w++) begin
            words_q[w] <= '0;
         end
         for (int l = 0; l < NUM_LIST; l++) begin
            ptr_q[l] <= '0;
         end
         err_ovf_q   <= 1'b0;
         err_fld_q   <= 1'b0;
         widx_q      <= '0;
         last_word_q <= 1'b0;
         done_q      <= 1'b0;
         boot_q      <= 1'b1;
         busy_q      <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         if (wr_en_s) begin
            words_q[wr_idx_s] <= wr_data;
         end
         ptr_q       <= ptr_d;
         err_ovf_q   <= err_ovf_d;
         err_fld_q   <= err_fld_d;
         widx_q      <= widx_d;
         last_word_q <= last_word_d;
         done_q      <= boot_q || frame_end_s;
         boot_q      <= 1'b0;
         busy_q      <= (state_d == ST_SEND);
         locked_q    <= (state_d == ST_LOCKED);
      end
   end

   p_config_word_serializer #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_word_ser (
      .clk          (clk),
      .reset_n      (reset_n),
      .word_valid_i (word_valid_s),
      .word_data_i  (word_data_s),
      .word_ready_o (word_ready_s),
      .beat_valid_o (beat_valid_s),
      .beat_data_o  (beat_data_s),
      .beat_last_o  (beat_last_s),
      .beat_ready_i (tx_ready)
   );

   assign tx_valid     = beat_valid_s;
   assign tx_data      = beat_data_s;
   assign tx_last      = beat_valid_s && beat_last_s && last_word_q;
   assign done_pulse   = done_q;
   assign busy         = busy_q;
   assign locked       = locked_q;
   assign err_overflow = err_ovf_q;
   assign err_field    = err_fld_q;

endmodule
